// File: rtl/obi_arb_pkg.sv
// +----------------------------------------------------------------------------+
// | Package    : obi_arb_pkg                                                   |
// | Description: Shared constants and index-width helper for the OBI arbiter.  |
// | Revision   : 1.0 - initial release                                         |
// +----------------------------------------------------------------------------+
`default_nettype none

package obi_arb_pkg;

    localparam int c_NUM_REQ_DEF         = 2;
    localparam int c_MAX_OUTSTANDING_DEF = 2;
    localparam int c_BE_WIDTH            = 4;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) begin
            r++;
        end
        return r;
    endfunction

endpackage

`default_nettype wire

// File: rtl/obi_arb_id_fifo.sv
// +----------------------------------------------------------------------------+
// | Module     : obi_arb_id_fifo                                               |
// | Description: Small FIFO holding the requester index of each granted,       |
// |              not-yet-answered OBI transaction.                             |
// | Revision   : 1.0 - initial release                                         |
// +----------------------------------------------------------------------------+
`default_nettype none

module obi_arb_id_fifo
    import obi_arb_pkg::*;
#(
    parameter int DEPTH = c_MAX_OUTSTANDING_DEF,
    parameter int WIDTH = 1
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);

    localparam int PTR_W = (clog2(DEPTH) < 1) ? 1 : clog2(DEPTH);
    localparam int CNT_W = clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wptr_q, wptr_d;
    logic [PTR_W-1:0] rptr_q, rptr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             do_push;
    logic             do_pop;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign empty = (cnt_q == '0);
    assign full  = (cnt_q == CNT_W'(DEPTH));
    assign dout  = mem_q[rptr_q];

    // The pop is applied first, so a full FIFO may accept a push alongside a pop.
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);

    always_comb begin
        wptr_d = do_push ? ptr_inc(wptr_q) : wptr_q;
        rptr_d = do_pop  ? ptr_inc(rptr_q) : rptr_q;
        cnt_d  = cnt_q;
        if (do_push && !do_pop) begin
            cnt_d = cnt_q + 1'b1;
        end else if (do_pop && !do_push) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wptr_q <= '0;
            rptr_q <= '0;
            cnt_q  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
            cnt_q  <= cnt_d;
            if (do_push) begin
                mem_q[wptr_q] <= din;
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/obi_rr_arbiter.sv
// +----------------------------------------------------------------------------+
// | Module     : obi_rr_arbiter                                                |
// | Description: Round-robin arbiter sharing one OBI slave among NumReq        |
// |              requesters, with address-phase lock and response routing.     |
// | Revision   : 1.0 - initial release                                         |
// +----------------------------------------------------------------------------+
`default_nettype none

module obi_rr_arbiter
    import obi_arb_pkg::*;
#(
    parameter int NumReq         = c_NUM_REQ_DEF,
    parameter int WordSize       = 32,
    parameter int AddrSize       = 32,
    parameter int MaxOutstanding = c_MAX_OUTSTANDING_DEF
) (
    input  logic                         s00_axi_aclk,
    input  logic                         s00_axi_aresetn,

    input  logic [NumReq-1:0]            m_req_i,
    output logic [NumReq-1:0]            m_gnt_o,
    input  logic [NumReq-1:0]            m_we_i,
    input  logic [NumReq*c_BE_WIDTH-1:0] m_be_i,
    input  logic [NumReq*AddrSize-1:0]   m_addr_i,
    input  logic [NumReq*WordSize-1:0]   m_wdata_i,
    output logic [NumReq-1:0]            m_rvalid_o,
    output logic [NumReq*WordSize-1:0]   m_rdata_o,

    output logic                         req_o,
    output logic                         we_o,
    output logic [c_BE_WIDTH-1:0]        be_o,
    output logic [AddrSize-1:0]          addr_o,
    output logic [WordSize-1:0]          wdata_o,
    input  logic                         gnt_i,
    input  logic                         rvalid_i,
    input  logic [WordSize-1:0]          rdata_i,

    output logic                         err_o
);

    localparam int IdxW = (clog2(NumReq) < 1) ? 1 : clog2(NumReq);

    logic [IdxW-1:0] last_grant_q, last_grant_d;
    logic [IdxW-1:0] lock_idx_q, lock_idx_d;
    logic            lock_q, lock_d;
    logic            err_q, err_d;

    logic [IdxW-1:0] rr_sel;
    logic [IdxW-1:0] sel;
    logic            any_req;
    logic            lock_drop;
    logic            hs;
    logic            pop;
    logic            fifo_full;
    logic            fifo_empty;
    logic [IdxW-1:0] fifo_dout;

    always_comb begin
        logic            found;
        logic [IdxW-1:0] cand;
        rr_sel = last_grant_q;
        found  = 1'b0;
        cand   = '0;
        for (int i = 1; i <= NumReq; i++) begin
            cand = IdxW'((int'(last_grant_q) + i) % NumReq);
            if (!found && m_req_i[cand]) begin
                rr_sel = cand;
                found  = 1'b1;
            end
        end
    end

    assign any_req   = |m_req_i;
    assign sel       = lock_q ? lock_idx_q : rr_sel;
    // A locked requester that drops its request gets no grant; the lock is released instead.
    assign lock_drop = lock_q & ~m_req_i[lock_idx_q];
    assign req_o     = s00_axi_aresetn & any_req & ~fifo_full & ~lock_drop;
    assign hs        = req_o & gnt_i;
    assign pop       = s00_axi_aresetn & rvalid_i & ~fifo_empty;
    assign err_o     = err_q;
    assign m_rdata_o = {NumReq{rdata_i}};

    always_comb begin
        we_o       = 1'b0;
        be_o       = '0;
        addr_o     = '0;
        wdata_o    = '0;
        m_gnt_o    = '0;
        m_rvalid_o = '0;
        for (int i = 0; i < NumReq; i++) begin
            if (sel == IdxW'(i)) begin
                we_o       = m_we_i[i];
                be_o       = m_be_i[i*c_BE_WIDTH +: c_BE_WIDTH];
                addr_o     = m_addr_i[i*AddrSize +: AddrSize];
                wdata_o    = m_wdata_i[i*WordSize +: WordSize];
                m_gnt_o[i] = hs;
            end
            if (fifo_dout == IdxW'(i)) begin
                m_rvalid_o[i] = pop;
            end
        end
    end

    always_comb begin
        lock_d       = lock_q;
        lock_idx_d   = lock_idx_q;
        last_grant_d = last_grant_q;
        err_d        = err_q | (rvalid_i & fifo_empty);
        if (hs) begin
            lock_d       = 1'b0;
            last_grant_d = sel;
        end else if (req_o) begin
            lock_d     = 1'b1;
            lock_idx_d = sel;
        end else if (lock_drop) begin
            lock_d = 1'b0;
        end
    end

    always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
        if (!s00_axi_aresetn) begin
            lock_q       <= 1'b0;
            lock_idx_q   <= '0;
            last_grant_q <= IdxW'(NumReq - 1);
            err_q        <= 1'b0;
        end else begin
            lock_q       <= lock_d;
            lock_idx_q   <= lock_idx_d;
            last_grant_q <= last_grant_d;
            err_q        <= err_d;
        end
    end

    obi_arb_id_fifo #(
        .DEPTH (MaxOutstanding),
        .WIDTH (IdxW)
    ) u_id_fifo (
        .clk_i  (s00_axi_aclk),
        .rst_ni (s00_axi_aresetn),
        .push   (hs),
        .pop    (pop),
        .din    (sel),
        .dout   (fifo_dout),
        .full   (fifo_full),
        .empty  (fifo_empty)
    );

endmodule

`default_nettype wire

// File: tb/tb_obi_rr_arbiter.sv
// +----------------------------------------------------------------------------+
// | Module     : tb_obi_rr_arbiter                                             |
// | Description: Directed scoreboard bench for obi_rr_arbiter (2 requesters).  |
// | Revision   : 1.0 - initial release                                         |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_obi_rr_arbiter;

    typedef struct {
        int          idx;
        logic [31:0] val;
    } exp_t;

    logic        clk;
    logic        rst_n;
    logic [1:0]  m_req_i;
    logic [1:0]  m_gnt_o;
    logic [1:0]  m_we_i;
    logic [7:0]  m_be_i;
    logic [63:0] m_addr_i;
    logic [63:0] m_wdata_i;
    logic [1:0]  m_rvalid_o;
    logic [63:0] m_rdata_o;
    logic        req_o;
    logic        we_o;
    logic [3:0]  be_o;
    logic [31:0] addr_o;
    logic [31:0] wdata_o;
    logic        gnt_i;
    logic        rvalid_i;
    logic [31:0] rdata_i;
    logic        err_o;

    exp_t q_gnt[$];
    exp_t q_rv[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    logic [31:0] a0 = 32'h2000_00A0;
    logic [31:0] a1 = 32'h3000_00B0;

    obi_rr_arbiter dut (
        .s00_axi_aclk    (clk),
        .s00_axi_aresetn (rst_n),
        .m_req_i         (m_req_i),
        .m_gnt_o         (m_gnt_o),
        .m_we_i          (m_we_i),
        .m_be_i          (m_be_i),
        .m_addr_i        (m_addr_i),
        .m_wdata_i       (m_wdata_i),
        .m_rvalid_o      (m_rvalid_o),
        .m_rdata_o       (m_rdata_o),
        .req_o           (req_o),
        .we_o            (we_o),
        .be_o            (be_o),
        .addr_o          (addr_o),
        .wdata_o         (wdata_o),
        .gnt_i           (gnt_i),
        .rvalid_i        (rvalid_i),
        .rdata_i         (rdata_i),
        .err_o           (err_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step(input logic [1:0] req, input logic gnt, input logic rv, input logic [31:0] rd);
        @(posedge clk);
        #1;
        m_req_i  = req;
        gnt_i    = gnt;
        rvalid_i = rv;
        rdata_i  = rd;
        m_addr_i = {a1, a0};
        #1;
    endtask

    task automatic exp_g(input int idx, input logic [31:0] addr);
        exp_t e;
        e.idx = idx;
        e.val = addr;
        q_gnt.push_back(e);
    endtask

    task automatic exp_r(input int idx, input logic [31:0] data);
        exp_t e;
        e.idx = idx;
        e.val = data;
        q_rv.push_back(e);
    endtask

    // Monitor: pops the scoreboard whenever a grant or response appears.
    always @(negedge clk) begin
        exp_t e;
        if (rst_n) begin
            if (m_gnt_o != 2'b00) begin
                if (q_gnt.size() == 0) begin
                    check("unexpected_gnt", {62'd0, m_gnt_o}, 64'd0);
                end else begin
                    e = q_gnt.pop_front();
                    check("gnt_owner", {62'd0, m_gnt_o}, 64'(2'b01 << e.idx));
                    check("gnt_addr", {32'd0, addr_o}, {32'd0, e.val});
                end
            end
            if (m_rvalid_o != 2'b00) begin
                if (q_rv.size() == 0) begin
                    check("unexpected_rvalid", {62'd0, m_rvalid_o}, 64'd0);
                end else begin
                    e = q_rv.pop_front();
                    check("rvalid_owner", {62'd0, m_rvalid_o}, 64'(2'b01 << e.idx));
                    check("rdata_route", {32'd0, m_rdata_o[e.idx*32 +: 32]}, {32'd0, e.val});
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n     = 1'b0;
        m_req_i   = 2'b11;
        gnt_i     = 1'b1;
        rvalid_i  = 1'b1;
        rdata_i   = 32'h0;
        m_we_i    = 2'b01;
        m_be_i    = 8'h3F;
        m_addr_i  = {a1, a0};
        m_wdata_i = {32'hCAFE_0001, 32'hCAFE_0000};
        #12;
        check("rst_req_o", {63'd0, req_o}, 64'd0);
        check("rst_gnt", {62'd0, m_gnt_o}, 64'd0);
        check("rst_rvalid", {62'd0, m_rvalid_o}, 64'd0);
        check("rst_err", {63'd0, err_o}, 64'd0);
        m_req_i  = 2'b00;
        gnt_i    = 1'b0;
        rvalid_i = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Alternating grants with responses one cycle behind.
        step(2'b11, 1'b1, 1'b0, 32'h0);
        exp_g(0, a0);
        check("rr_req_o", {63'd0, req_o}, 64'd1);
        check("mux_we", {63'd0, we_o}, 64'd1);
        check("mux_be", {60'd0, be_o}, 64'hF);
        check("mux_wdata", {32'd0, wdata_o}, 64'hCAFE_0000);
        step(2'b11, 1'b1, 1'b1, 32'h1111_1111); exp_g(1, a1); exp_r(0, 32'h1111_1111);
        step(2'b11, 1'b1, 1'b1, 32'h2222_2222); exp_g(0, a0); exp_r(1, 32'h2222_2222);
        step(2'b11, 1'b1, 1'b1, 32'h3333_3333); exp_g(1, a1); exp_r(0, 32'h3333_3333);
        check("mux_be1", {60'd0, be_o}, 64'h3);
        step(2'b00, 1'b0, 1'b1, 32'h4444_4444); exp_r(1, 32'h4444_4444);
        check("idle_req_o", {63'd0, req_o}, 64'd0);

        // Lock holds requester 1 while gnt_i is low, then FIFO-full blocking.
        a1 = 32'h1000_0040;
        step(2'b10, 1'b0, 1'b0, 32'h0);
        check("lock_addr_c0", {32'd0, addr_o}, {32'd0, a1});
        step(2'b10, 1'b0, 1'b0, 32'h0);
        check("lock_addr_c1", {32'd0, addr_o}, {32'd0, a1});
        step(2'b11, 1'b0, 1'b0, 32'h0);
        check("lock_addr_c2", {32'd0, addr_o}, {32'd0, a1});
        check("lock_no_gnt", {62'd0, m_gnt_o}, 64'd0);
        step(2'b11, 1'b1, 1'b0, 32'h0); exp_g(1, a1);
        step(2'b11, 1'b1, 1'b0, 32'h0); exp_g(0, a0);
        step(2'b11, 1'b1, 1'b0, 32'h0);
        check("full_req_o", {63'd0, req_o}, 64'd0);
        step(2'b11, 1'b1, 1'b1, 32'h5555_5555); exp_r(1, 32'h5555_5555);
        check("full_pop_req_o", {63'd0, req_o}, 64'd0);
        step(2'b11, 1'b1, 1'b0, 32'h0); exp_g(1, a1);
        step(2'b00, 1'b0, 1'b1, 32'h6666_6666); exp_r(0, 32'h6666_6666);
        step(2'b00, 1'b0, 1'b1, 32'h7777_7777); exp_r(1, 32'h7777_7777);

        // Push and pop in the same cycle keep the count at one.
        step(2'b01, 1'b1, 1'b0, 32'h0); exp_g(0, a0);
        step(2'b10, 1'b1, 1'b1, 32'h8888_8888); exp_g(1, a1); exp_r(0, 32'h8888_8888);
        step(2'b01, 1'b1, 1'b0, 32'h0); exp_g(0, a0);
        step(2'b11, 1'b1, 1'b0, 32'h0);
        check("count_kept_req_o", {63'd0, req_o}, 64'd0);
        step(2'b00, 1'b0, 1'b1, 32'h9999_9999); exp_r(1, 32'h9999_9999);
        step(2'b00, 1'b0, 1'b1, 32'hAAAA_AAAA); exp_r(0, 32'hAAAA_AAAA);
        check("no_err_yet", {63'd0, err_o}, 64'd0);

        // Unexpected response after reset.
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        step(2'b00, 1'b0, 1'b1, 32'hBBBB_BBBB);
        check("drop_rvalid", {62'd0, m_rvalid_o}, 64'd0);
        step(2'b00, 1'b0, 1'b0, 32'h0);
        check("err_set", {63'd0, err_o}, 64'd1);
        step(2'b00, 1'b0, 1'b0, 32'h0);
        check("err_sticky", {63'd0, err_o}, 64'd1);

        // Reset with one ID outstanding discards it.
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("err_cleared", {63'd0, err_o}, 64'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        step(2'b10, 1'b1, 1'b0, 32'h0); exp_g(1, a1);
        @(posedge clk);
        #2;
        rst_n    = 1'b0;
        m_req_i  = 2'b11;
        gnt_i    = 1'b1;
        rvalid_i = 1'b1;
        rdata_i  = 32'hDEAD_BEEF;
        #1;
        check("mid_rst_req_o", {63'd0, req_o}, 64'd0);
        check("mid_rst_gnt", {62'd0, m_gnt_o}, 64'd0);
        check("mid_rst_rvalid", {62'd0, m_rvalid_o}, 64'd0);
        check("mid_rst_err", {63'd0, err_o}, 64'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        #1;
        exp_g(0, a0);
        check("post_rst_no_rvalid", {62'd0, m_rvalid_o}, 64'd0);
        step(2'b00, 1'b0, 1'b0, 32'h0);
        check("post_rst_err", {63'd0, err_o}, 64'd1);

        @(negedge clk);
        #1;
        check("gnt_queue_empty", 64'(q_gnt.size()), 64'd0);
        check("rv_queue_empty", 64'(q_rv.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
